// File: rtl/ahblite_busmatrix_pkg.sv
// rtl/ahblite_busmatrix_pkg.sv - shared encodings and field widths for the AHB-Lite bus matrix
package ahblite_busmatrix_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        PORT_NONE = 2'b00,
        PORT_SYS  = 2'b01,
        PORT_DMA  = 2'b10
    } port_sel_e;

    localparam int HTRANS_W = 2;
    localparam int HSIZE_W  = 3;
    localparam int HBURST_W = 3;
    localparam int HPROT_W  = 4;

    // NONSEQ and SEQ carry a real transfer; IDLE and BUSY never do
    function automatic logic is_xfer(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahblite_busmatrix_holdreg.sv
// rtl/ahblite_busmatrix_holdreg.sv - address-phase capture register with load enable and async clear
module ahblite_busmatrix_holdreg #(
    parameter int W = 1
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // capture on load, otherwise keep; reset discards any captured phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ahblite_busmatrix_inputstage.sv
// rtl/ahblite_busmatrix_inputstage.sv - per-master input stage: stalls and holds ungranted address phases
module ahblite_busmatrix_inputstage
    import ahblite_busmatrix_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [HTRANS_W-1:0]   HTRANS,
    input  logic                  HWRITE,
    input  logic [HSIZE_W-1:0]    HSIZE,
    input  logic [HBURST_W-1:0]   HBURST,
    input  logic [HPROT_W-1:0]    HPROT,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  HSEL_O,
    output logic [ADDR_WIDTH-1:0] HADDR_O,
    output logic [HTRANS_W-1:0]   HTRANS_O,
    output logic                  HWRITE_O,
    output logic [HSIZE_W-1:0]    HSIZE_O,
    output logic [HBURST_W-1:0]   HBURST_O,
    output logic [HPROT_W-1:0]    HPROT_O,
    output logic                  TRANS_REQ,
    input  logic                  ACTIVE_Decoder,
    input  logic                  HREADYOUT_Decoder,
    input  logic                  HRESP_Decoder
);

    localparam int AP_W = 1 + ADDR_WIDTH + HTRANS_W + 1 + HSIZE_W + HBURST_W + HPROT_W;

    logic            pend;
    logic            dphase;
    logic            trans_valid;
    logic            accept;
    logic            hold_load;
    logic [AP_W-1:0] live_ap;
    logic [AP_W-1:0] hold_ap;
    logic [AP_W-1:0] out_ap;

    assign trans_valid = HSEL & is_xfer(HTRANS) & HREADY;

    // an address phase leaves this stage when the granted output stage is ready
    assign accept = (trans_valid | pend) & ACTIVE_Decoder & HREADYOUT_Decoder;

    // the hold register is frozen while a captured phase is outstanding
    assign hold_load = trans_valid & ~ACTIVE_Decoder & ~pend;

    assign live_ap = {HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT};

    ahblite_busmatrix_holdreg #(
        .W (AP_W)
    ) u_holdreg (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .load    (hold_load),
        .d       (live_ap),
        .q       (hold_ap)
    );

    // pend: an ungranted transfer is parked here until the grant and downstream ready meet
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend <= 1'b0;
        end else if (hold_load) begin
            pend <= 1'b1;
        end else if (pend & ACTIVE_Decoder & HREADYOUT_Decoder) begin
            pend <= 1'b0;
        end
    end

    // dphase: this port owns the downstream data phase until it completes
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dphase <= 1'b0;
        end else if (accept) begin
            dphase <= 1'b1;
        end else if (HREADYOUT_Decoder) begin
            dphase <= 1'b0;
        end
    end

    assign out_ap = pend ? hold_ap : live_ap;
    assign {HSEL_O, HADDR_O, HTRANS_O, HWRITE_O, HSIZE_O, HBURST_O, HPROT_O} = out_ap;

    assign TRANS_REQ = HSEL_O & HTRANS_O[1];

    // pend stalls the master outright; otherwise the downstream data phase drives the response
    assign HREADYOUT = pend ? 1'b0 : (dphase ? HREADYOUT_Decoder : 1'b1);
    assign HRESP     = (dphase & ~pend) ? HRESP_Decoder : HRESP_OKAY;

endmodule

// File: tb/tb_ahblite_busmatrix_inputstage.sv
// tb/tb_ahblite_busmatrix_inputstage.sv - self-checking bench for the bus matrix input stage
module tb_ahblite_busmatrix_inputstage;
    import ahblite_busmatrix_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic        HSEL_O;
    logic [31:0] HADDR_O;
    logic [1:0]  HTRANS_O;
    logic        HWRITE_O;
    logic [2:0]  HSIZE_O;
    logic [2:0]  HBURST_O;
    logic [3:0]  HPROT_O;
    logic        TRANS_REQ;
    logic        ACTIVE_Decoder;
    logic        HREADYOUT_Decoder;
    logic        HRESP_Decoder;

    always #5 HCLK = ~HCLK;

    ahblite_busmatrix_inputstage #(
        .ADDR_WIDTH (32)
    ) dut (
        .HCLK              (HCLK),
        .HRESETn           (HRESETn),
        .HSEL              (HSEL),
        .HADDR             (HADDR),
        .HTRANS            (HTRANS),
        .HWRITE            (HWRITE),
        .HSIZE             (HSIZE),
        .HBURST            (HBURST),
        .HPROT             (HPROT),
        .HREADY            (HREADY),
        .HREADYOUT         (HREADYOUT),
        .HRESP             (HRESP),
        .HSEL_O            (HSEL_O),
        .HADDR_O           (HADDR_O),
        .HTRANS_O          (HTRANS_O),
        .HWRITE_O          (HWRITE_O),
        .HSIZE_O           (HSIZE_O),
        .HBURST_O          (HBURST_O),
        .HPROT_O           (HPROT_O),
        .TRANS_REQ         (TRANS_REQ),
        .ACTIVE_Decoder    (ACTIVE_Decoder),
        .HREADYOUT_Decoder (HREADYOUT_Decoder),
        .HRESP_Decoder     (HRESP_Decoder)
    );

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
    } aphase_t;

    // reference model: parked transfers awaiting a grant, and data-phase ownership
    aphase_t parked_q[$];
    bit      owns_dp;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic aphase_t live_ap();
        aphase_t a;
        a.sel   = HSEL;
        a.addr  = HADDR;
        a.trans = HTRANS;
        a.wr    = HWRITE;
        a.size  = HSIZE;
        a.burst = HBURST;
        a.prot  = HPROT;
        return a;
    endfunction

    function automatic logic model_ready();
        if (parked_q.size() != 0) return 1'b0;
        if (owns_dp) return HREADYOUT_Decoder;
        return 1'b1;
    endfunction

    function automatic logic model_resp();
        if (owns_dp && parked_q.size() == 0) return HRESP_Decoder;
        return 1'b0;
    endfunction

    task automatic check_all(input string ctx);
        aphase_t e;
        e = (parked_q.size() != 0) ? parked_q[0] : live_ap();
        check({ctx, ".hreadyout"}, 64'(HREADYOUT), 64'(model_ready()));
        check({ctx, ".hresp"},     64'(HRESP),     64'(model_resp()));
        check({ctx, ".hsel_o"},    64'(HSEL_O),    64'(e.sel));
        check({ctx, ".haddr_o"},   64'(HADDR_O),   64'(e.addr));
        check({ctx, ".htrans_o"},  64'(HTRANS_O),  64'(e.trans));
        check({ctx, ".hwrite_o"},  64'(HWRITE_O),  64'(e.wr));
        check({ctx, ".hsize_o"},   64'(HSIZE_O),   64'(e.size));
        check({ctx, ".hburst_o"},  64'(HBURST_O),  64'(e.burst));
        check({ctx, ".hprot_o"},   64'(HPROT_O),   64'(e.prot));
        check({ctx, ".trans_req"}, 64'(TRANS_REQ), 64'(e.sel & (e.trans == HTRANS_NONSEQ || e.trans == HTRANS_SEQ)));
    endtask

    task automatic model_edge();
        bit master_xfer;
        bit parked;
        bit goes_down;
        master_xfer = HSEL && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ) && HREADY;
        parked      = parked_q.size() != 0;
        goes_down   = (master_xfer || parked) && ACTIVE_Decoder && HREADYOUT_Decoder;
        if (master_xfer && !ACTIVE_Decoder && !parked) parked_q.push_back(live_ap());
        else if (parked && ACTIVE_Decoder && HREADYOUT_Decoder) void'(parked_q.pop_front());
        if (goes_down) owns_dp = 1'b1;
        else if (HREADYOUT_Decoder) owns_dp = 1'b0;
    endtask

    // one clock: drive at edge+1, check at edge+4, advance model on the edge
    task automatic step(input string ctx, input logic sel, input logic [1:0] tr,
                        input logic [31:0] addr, input logic wr,
                        input logic act, input logic rdyd, input logic respd);
        HSEL              = sel;
        HTRANS            = tr;
        HADDR             = addr;
        HWRITE            = wr;
        HSIZE             = 3'($urandom_range(0, 7));
        HBURST            = 3'($urandom_range(0, 7));
        HPROT             = 4'($urandom_range(0, 15));
        ACTIVE_Decoder    = act;
        HREADYOUT_Decoder = rdyd;
        HRESP_Decoder     = respd;
        HREADY            = model_ready();
        #3;
        check_all(ctx);
        @(posedge HCLK);
        model_edge();
        #1;
    endtask

    initial begin
        owns_dp           = 1'b0;
        HRESETn           = 1'b0;
        HSEL              = 1'b1;
        HTRANS            = HTRANS_NONSEQ;
        HADDR             = 32'h1234_5678;
        HWRITE            = 1'b1;
        HSIZE             = 3'd2;
        HBURST            = 3'd0;
        HPROT             = 4'h3;
        HREADY            = 1'b1;
        ACTIVE_Decoder    = 1'b0;
        HREADYOUT_Decoder = 1'b1;
        HRESP_Decoder     = 1'b0;
        #7;
        check_all("reset");
        @(posedge HCLK);
        #1;
        check_all("reset_edge");
        HRESETn = 1'b1;

        // granted pass-through
        step("grant_wr", 1, HTRANS_NONSEQ, 32'h2000_0000, 1, 1, 1, 0);
        step("grant_dp", 1, HTRANS_IDLE,   32'h0000_0000, 0, 1, 1, 0);

        // stall and release after the grant arrives three cycles later
        step("stall_cap", 1, HTRANS_NONSEQ, 32'h4000_0010, 0, 0, 1, 0);
        step("stall_1",   1, HTRANS_IDLE,   32'h5555_0000, 1, 0, 1, 0);
        step("stall_2",   0, HTRANS_NONSEQ, 32'h6666_0000, 1, 0, 1, 0);
        step("stall_rel", 1, HTRANS_IDLE,   32'h7777_0000, 0, 1, 1, 0);
        step("rel_dp0",   1, HTRANS_IDLE,   32'h0000_0000, 0, 1, 0, 0);
        step("rel_dp1",   1, HTRANS_IDLE,   32'h0000_0000, 0, 1, 1, 0);

        // downstream wait states
        step("ws_addr", 1, HTRANS_NONSEQ, 32'h2000_0040, 0, 1, 1, 0);
        step("ws_w1",   1, HTRANS_IDLE,   32'h0000_0000, 0, 1, 0, 0);
        step("ws_w2",   1, HTRANS_IDLE,   32'h0000_0000, 0, 1, 0, 0);
        step("ws_done", 1, HTRANS_IDLE,   32'h0000_0000, 0, 1, 1, 0);

        // two-cycle error response, master cancels with IDLE
        step("err_addr", 1, HTRANS_NONSEQ, 32'h2000_0080, 1, 1, 1, 0);
        step("err_c1",   1, HTRANS_IDLE,   32'h0000_0000, 0, 1, 0, 1);
        step("err_c2",   1, HTRANS_IDLE,   32'h2000_0084, 0, 0, 1, 1);
        step("err_post", 1, HTRANS_IDLE,   32'h0000_0000, 0, 0, 1, 0);

        // IDLE and BUSY are never parked
        step("idle_nogr", 1, HTRANS_IDLE, 32'h4000_0100, 0, 0, 1, 0);
        step("busy_nogr", 1, HTRANS_BUSY, 32'h4000_0104, 0, 0, 1, 0);
        step("busy_after", 1, HTRANS_IDLE, 32'h4000_0108, 0, 0, 1, 0);

        // asynchronous reset while a transfer is parked
        step("rst_cap", 1, HTRANS_NONSEQ, 32'h4000_0200, 1, 0, 1, 0);
        HADDR  = 32'h9abc_def0;
        HTRANS = HTRANS_NONSEQ;
        #2;
        HRESETn = 1'b0;
        #1;
        parked_q.delete();
        owns_dp = 1'b0;
        HREADY  = model_ready();
        check_all("rst_async");
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        step("rst_after", 1, HTRANS_IDLE, 32'h0000_0000, 0, 1, 1, 0);

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 logic'($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)),
                 $urandom(),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 2) != 0),
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
